// File: rtl/mult_acc_pkg.sv
// Shared defaults and the tag carried alongside each product through the
// multiplier latency.
package mult_acc_pkg;

    localparam int ACC_W_DEF        = 48;
    localparam int MULT_LATENCY_DEF = 5;
    localparam int FIFO_DEPTH_DEF   = 2;
    localparam int MULT_W           = 36;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

endpackage

// File: rtl/mult_acc_result_fifo.sv
// Small synchronous result queue; the head is presented combinationally and
// reads as zero while empty.
module mult_acc_result_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mult_accumulator.sv
// Dot-product accumulator behind a fixed-latency multiplier. Define
// MULT_ACC_SATURATE_EN to clamp on overflow and report OVF; otherwise sums wrap.
module mult_accumulator
    import mult_acc_pkg::*;
#(
    parameter int ACC_W        = ACC_W_DEF,
    parameter int MULT_LATENCY = MULT_LATENCY_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    input  logic              IN_LAST,
    output logic              IN_READY,
    input  logic [MULT_W-1:0] MULT,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [ACC_W-1:0]  SUM,
    output logic              OVF
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    tag_t             tag_line [MULT_LATENCY];
    tag_t             tag_out;
    logic             accept, push, pop, empty;
    logic [CNT_W-1:0] last_cnt, fifo_cnt;
    logic [CNT_W:0]   credit_used;
    logic             first;
    logic [ACC_W-1:0] acc, acc_next;
    logic             ovf_next;

    assign tag_out = tag_line[MULT_LATENCY-1];

    // Every last tag still in flight reserves a FIFO slot, so a push can never
    // find the queue full.
    assign credit_used = {1'b0, fifo_cnt} + {1'b0, last_cnt};
    assign IN_READY    = credit_used < (CNT_W+1)'(FIFO_DEPTH);
    assign accept      = IN_VALID & IN_READY;
    assign push        = tag_out.valid & tag_out.last;
    assign pop         = OUT_VALID & OUT_READY;

`ifdef MULT_ACC_SATURATE_EN
    logic [ACC_W:0] add;
    logic           ovf_trk;

    assign add      = (first ? '0 : {1'b0, acc}) + (ACC_W+1)'(MULT);
    assign ovf_next = add[ACC_W] | (ovf_trk & ~first);
    assign acc_next = ovf_next ? '1 : add[ACC_W-1:0];

    always_ff @(posedge CLK) begin
        if (!RST_N)             ovf_trk <= 1'b0;
        else if (tag_out.valid) ovf_trk <= ovf_next;
    end
`else
    logic [ACC_W-1:0] add;

    assign add      = (first ? '0 : acc) + ACC_W'(MULT);
    assign ovf_next = 1'b0;
    assign acc_next = add;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < MULT_LATENCY; i++) tag_line[i] <= '0;
            last_cnt <= '0;
            first    <= 1'b1;
            acc      <= '0;
        end else begin
            tag_line[0] <= '{valid: accept, last: accept & IN_LAST};
            for (int i = 1; i < MULT_LATENCY; i++) tag_line[i] <= tag_line[i-1];
            last_cnt <= last_cnt + CNT_W'(accept & IN_LAST) - CNT_W'(push);
            if (tag_out.valid) begin
                first <= tag_out.last;
                acc   <= acc_next;
            end
        end
    end

    mult_acc_result_fifo #(
        .WIDTH (ACC_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push),
        .din   ({ovf_next, acc_next}),
        .pop   (pop),
        .dout  ({OVF, SUM}),
        .empty (empty),
        .count (fifo_cnt)
    );

    assign OUT_VALID = ~empty;

endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: a 48-bit and a 36-bit instance share stimulus and
// are checked against a sum/queue reference model plus literal scenario values.
module tb_mult_accumulator;

    localparam int LAT   = 5;
    localparam int DEPTH = 2;

    typedef struct {
        logic [63:0] sum;
        int          due;
    } pend_t;

    logic        CLK = 0, RST_N = 0, IN_VALID = 0, IN_LAST = 0, OUT_READY = 1;
    logic [17:0] A = 0, B = 0;
    logic [35:0] MULT;
    logic [35:0] mpipe [LAT];
    logic        IN_READY, OUT_VALID, OVF, IN_READY36, OUT_VALID36, OVF36;
    logic [47:0] SUM;
    logic [35:0] SUM36;

    int          tests = 0, fails = 0, cyc = 0, ready_mode = 0;
    bit          chk_en = 0;
    pend_t       inflight [$];
    logic [63:0] mfifo [$];
    logic [63:0] popped [$];
    logic [63:0] vsum = 0;
    pend_t       pp;

    mult_accumulator #(.ACC_W(48), .MULT_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
        .IN_READY(IN_READY), .MULT(MULT), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .SUM(SUM), .OVF(OVF));

    mult_accumulator #(.ACC_W(36), .MULT_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut36 (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
        .IN_READY(IN_READY36), .MULT(MULT), .OUT_VALID(OUT_VALID36),
        .OUT_READY(OUT_READY), .SUM(SUM36), .OVF(OVF36));

    always #5 CLK = ~CLK;

    // Upstream 18x18 multiplier: product of A/B sampled at an edge shows LAT cycles later.
    always @(posedge CLK) begin
        mpipe[0] <= A * B;
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign MULT = mpipe[LAT-1];

    function automatic logic [63:0] exp_sum(input logic [63:0] t, input int w);
        logic [63:0] lim;
        lim = 64'd1 << w;
        if (t < lim) return t;
`ifdef MULT_ACC_SATURATE_EN
        return lim - 1;
`else
        return t & (lim - 1);
`endif
    endfunction

    function automatic logic [63:0] exp_ovf(input logic [63:0] t, input int w);
`ifdef MULT_ACC_SATURATE_EN
        return {63'd0, t >= (64'd1 << w)};
`else
        return 64'd0;
`endif
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: true dot products, ready times, and a result queue.
    initial forever begin
        @(posedge CLK);
        if (!RST_N) begin
            inflight.delete();
            mfifo.delete();
            vsum = 0;
        end else begin
            logic mready;
            mready = (mfifo.size() + inflight.size()) < DEPTH;
            if (mfifo.size() != 0 && OUT_READY) void'(mfifo.pop_front());
            if (IN_VALID && mready) begin
                vsum += 64'(A) * 64'(B);
                if (IN_LAST) begin
                    inflight.push_back('{sum: vsum, due: cyc + LAT + 1});
                    vsum = 0;
                end
            end
        end
        cyc++;
    end

    // Per-cycle compare of both instances against the model.
    initial forever begin
        @(negedge CLK);
        while (inflight.size() > 0 && inflight[0].due <= cyc) begin
            pp = inflight.pop_front();
            mfifo.push_back(pp.sum);
        end
        if (OUT_VALID && OUT_READY) popped.push_back(64'(SUM));
        if (chk_en) begin
            check("in_ready",     64'(IN_READY),    64'((mfifo.size() + inflight.size()) < DEPTH));
            check("in_ready36",   64'(IN_READY36),  64'((mfifo.size() + inflight.size()) < DEPTH));
            check("out_valid",    64'(OUT_VALID),   64'(mfifo.size() != 0));
            check("out_valid36",  64'(OUT_VALID36), 64'(mfifo.size() != 0));
            if (mfifo.size() != 0) begin
                check("sum48", 64'(SUM),   exp_sum(mfifo[0], 48));
                check("ovf48", 64'(OVF),   exp_ovf(mfifo[0], 48));
                check("sum36", 64'(SUM36), exp_sum(mfifo[0], 36));
                check("ovf36", 64'(OVF36), exp_ovf(mfifo[0], 36));
            end
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        OUT_READY = (ready_mode == 0) ? 1'b1 :
                    (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    task automatic idle(input int n);
        repeat (n) begin
            A = 18'($urandom);
            B = 18'($urandom);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
        int n;
        n = 0;
        A = a; B = b; IN_LAST = last; IN_VALID = 1;
        @(negedge CLK);
        while (!IN_READY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 300) check("send_timeout", 64'(IN_READY), 64'd1);
        @(posedge CLK);
        #1;
        IN_VALID = 0; IN_LAST = 0;
        A = 18'($urandom); B = 18'($urandom);
    endtask

    task automatic wait_out(input string nm, input logic [63:0] e48, input logic [63:0] e36,
                            input logic [63:0] eovf36, output int at);
        int n;
        n = 0;
        @(negedge CLK);
        while (!OUT_VALID && n < 100) begin
            @(negedge CLK);
            n++;
        end
        at = cyc;
        check({nm, "_valid"}, 64'(OUT_VALID), 64'd1);
        check({nm, "_sum48"}, 64'(SUM), e48);
        check({nm, "_ovf48"}, 64'(OVF), 64'd0);
        check({nm, "_sum36"}, 64'(SUM36), e36);
        check({nm, "_ovf36"}, 64'(OVF36), eovf36);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int c0, at;
        logic [17:0] ra, rb;
        int len;

        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1;
        @(negedge CLK);
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_sum",       64'(SUM),       64'd0);
        check("rst_ovf",       64'(OVF),       64'd0);
        check("rst_in_ready",  64'(IN_READY),  64'd1);
        check("rst_in_ready36", 64'(IN_READY36), 64'd1);
        chk_en = 1;
        @(posedge CLK);
        #1;

        // Three-term vector, back-to-back acceptance
        send(18'd2, 18'd3, 0);
        c0 = cyc - 1;
        send(18'd4, 18'd5, 0);
        send(18'd6, 18'd7, 1);
        wait_out("dot3", 64'd68, 64'd68, 64'd0, at);
        check("dot3_latency", 64'(at - c0), 64'd8);

        // Largest single product
        send(18'h3FFFF, 18'h3FFFF, 1);
        wait_out("maxprod", 64'hFFFF80001, 64'hFFFF80001, 64'd0, at);

        // Backpressure: credit blocks the third vector until results drain
        idle(2);
        ready_mode = 1;
        idle(2);
        popped.delete();
        send(18'd1, 18'd1, 1);
        send(18'd2, 18'd2, 1);
        @(negedge CLK);
        check("credit_block", 64'(IN_READY), 64'd0);
        @(posedge CLK);
        #1;
        fork
            send(18'd3, 18'd3, 1);
            begin
                repeat (10) @(negedge CLK);
                check("held_valid", 64'(OUT_VALID), 64'd1);
                check("held_sum",   64'(SUM),       64'd1);
                check("held_block", 64'(IN_READY),  64'd0);
                ready_mode = 0;
            end
        join
        idle(15);
        check("order_count", 64'(popped.size()), 64'd3);
        check("order_0", popped[0], 64'd1);
        check("order_1", popped[1], 64'd4);
        check("order_2", popped[2], 64'd9);

        // Two max terms: exceeds 36 bits, fits 48
        send(18'h3FFFF, 18'h3FFFF, 0);
        send(18'h3FFFF, 18'h3FFFF, 1);
`ifdef MULT_ACC_SATURATE_EN
        wait_out("ovf", 64'h1FFFF00002, 64'hFFFFFFFFF, 64'd1, at);
`else
        wait_out("ovf", 64'h1FFFF00002, 64'hFFFF00002, 64'd0, at);
`endif

        // Reset mid-vector discards partial sum and in-flight products
        popped.delete();
        send(18'd5, 18'd5, 0);
        send(18'd5, 18'd5, 0);
        RST_N = 0;
        @(posedge CLK);
        #1;
        RST_N = 1;
        send(18'd1, 18'd1, 1);
        wait_out("after_rst", 64'd1, 64'd1, 64'd0, at);
        idle(15);
        check("after_rst_count", 64'(popped.size()), 64'd1);

        // Gaps between terms with garbage products
        send(18'd1, 18'd2, 0);
        idle(3);
        send(18'd3, 18'd4, 1);
        wait_out("gaps", 64'd14, 64'd14, 64'd0, at);

        // Randomized vectors, gaps and backpressure
        ready_mode = 2;
        for (int v = 0; v < 200; v++) begin
            len = $urandom_range(1, 4);
            for (int t = 0; t < len; t++) begin
                ra = ($urandom_range(0, 3) == 0) ? 18'h3FFFF : 18'($urandom);
                rb = ($urandom_range(0, 3) == 0) ? 18'h3FFFF : 18'($urandom);
                send(ra, rb, t == len - 1);
                idle($urandom_range(0, 2));
            end
        end
        ready_mode = 0;
        idle(30);
        check("drained", 64'(OUT_VALID), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
